// File: rtl/tm1637_responder.sv
// TM1637 bus slave: decodes data/address/display commands, strobes display writes, answers key reads.
// Optional display register file with read port when TM1637_RESPONDER_RAM_EN is defined.
module tm1637_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_DIGITS  = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tm1637_clk,
   input  logic       tm1637_dio,
   output logic       dio_oe,
   input  logic [7:0] key_code,
   output logic       wr_en,
   output logic [2:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       display_on,
   output logic [2:0] brightness,
   output logic       frame_err,
`ifdef TM1637_RESPONDER_RAM_EN
   input  logic [2:0] rd_addr,
   output logic [7:0] rd_data,
`endif
   output logic [2:0] dbg_state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RX   = 3'd1;
   localparam logic [2:0] S_ACK  = 3'd2;
   localparam logic [2:0] S_TX   = 3'd3;
   localparam logic [2:0] S_WAIT = 3'd4;

   // What the next received byte means within the current frame.
   localparam logic [1:0] K_CMD    = 2'd0;
   localparam logic [1:0] K_DATA   = 2'd1;
   localparam logic [1:0] K_EXTRA  = 2'd2;
   localparam logic [1:0] K_IGNORE = 2'd3;

   localparam logic [2:0] LAST_ADDR = 3'(NUM_DIGITS - 1);
   localparam logic [3:0] NUM_D4    = 4'(NUM_DIGITS);

   logic [SYNC_STAGES-1:0] r_clk_sync, r_dio_sync;
   logic r_clk_d, r_dio_d;
   logic w_clk, w_dio, w_clk_rise, w_clk_fall, w_start, w_stop;

   logic [2:0] r_state;
   logic [3:0] r_bitcnt;
   logic [7:0] r_shift;
   logic [1:0] r_kind;
   logic [2:0] r_ptr;
   logic       r_fixed;
   logic       r_tx_go;
   logic [7:0] r_key;
   logic [3:0] r_txcnt;

   // Synchronisers idle high to match the released bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= '1;
         r_dio_sync <= '1;
         r_clk_d    <= 1'b1;
         r_dio_d    <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], tm1637_clk};
         r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], tm1637_dio};
         r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
         r_dio_d    <= r_dio_sync[SYNC_STAGES-1];
      end
   end

   assign w_clk      = r_clk_sync[SYNC_STAGES-1];
   assign w_dio      = r_dio_sync[SYNC_STAGES-1];
   assign w_clk_rise = w_clk & ~r_clk_d;
   assign w_clk_fall = ~w_clk & r_clk_d;
   assign w_start    = w_clk & r_clk_d & r_dio_d & ~w_dio;
   assign w_stop     = w_clk & r_clk_d & ~r_dio_d & w_dio;
   assign dbg_state  = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bitcnt   <= 4'd0;
         r_shift    <= 8'd0;
         r_kind     <= K_CMD;
         r_ptr      <= 3'd0;
         r_fixed    <= 1'b0;
         r_tx_go    <= 1'b0;
         r_key      <= 8'd0;
         r_txcnt    <= 4'd0;
         dio_oe     <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= 3'd0;
         wr_data    <= 8'd0;
         display_on <= 1'b0;
         brightness <= 3'd0;
         frame_err  <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         frame_err <= 1'b0;
         if (w_start) begin
            if (r_state == S_RX && r_bitcnt != 4'd0) frame_err <= 1'b1;
            r_state  <= S_RX;
            r_bitcnt <= 4'd0;
            r_kind   <= K_CMD;
            r_tx_go  <= 1'b0;
            dio_oe   <= 1'b0;
         end else if (w_stop) begin
            r_state <= S_IDLE;
            r_tx_go <= 1'b0;
            dio_oe  <= 1'b0;
         end else begin
            case (r_state)
               S_RX: begin
                  if (w_clk_rise && r_bitcnt < 4'd8) begin
                     r_shift[r_bitcnt[2:0]] <= w_dio;
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end else if (w_clk_fall && r_bitcnt == 4'd8) begin
                     r_state <= S_ACK;
                     dio_oe  <= 1'b1;
                     case (r_kind)
                        K_CMD: begin
                           case (r_shift[7:6])
                              2'b01: begin
                                 r_fixed <= r_shift[2];
                                 r_kind  <= K_EXTRA;
                                 if (r_shift[1:0] == 2'b10) begin
                                    r_tx_go <= 1'b1;
                                    r_key   <= key_code;
                                 end
                              end
                              2'b11: begin
                                 r_ptr  <= r_shift[2:0];
                                 r_kind <= K_DATA;
                              end
                              2'b10: begin
                                 display_on <= r_shift[3];
                                 brightness <= r_shift[2:0];
                                 r_kind     <= K_EXTRA;
                              end
                              default: begin
                                 frame_err <= 1'b1;
                                 r_kind    <= K_IGNORE;
                              end
                           endcase
                        end
                        K_DATA: begin
                           if ({1'b0, r_ptr} < NUM_D4) begin
                              wr_en   <= 1'b1;
                              wr_addr <= r_ptr;
                              wr_data <= r_shift;
                           end else begin
                              frame_err <= 1'b1;
                           end
                           if (!r_fixed) r_ptr <= (r_ptr == LAST_ADDR) ? 3'd0 : r_ptr + 3'd1;
                        end
                        K_EXTRA: frame_err <= 1'b1;
                        default: ;
                     endcase
                  end
               end
               S_ACK: begin
                  if (w_clk_fall) begin
                     r_bitcnt <= 4'd0;
                     if (r_tx_go) begin
                        r_state <= S_TX;
                        r_tx_go <= 1'b0;
                        dio_oe  <= ~r_key[0];
                        r_txcnt <= 4'd1;
                     end else begin
                        r_state <= S_RX;
                        dio_oe  <= 1'b0;
                     end
                  end
               end
               S_TX: begin
                  if (w_clk_fall) begin
                     if (r_txcnt == 4'd8) begin
                        dio_oe  <= 1'b0;
                        r_state <= S_WAIT;
                     end else begin
                        dio_oe  <= ~r_key[r_txcnt[2:0]];
                        r_txcnt <= r_txcnt + 4'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TM1637_RESPONDER_RAM_EN
   logic [7:0] r_ram [0:NUM_DIGITS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_ram[i] <= 8'd0;
         rd_data <= 8'd0;
      end else begin
         if (wr_en) r_ram[wr_addr] <= wr_data;
         rd_data <= ({1'b0, rd_addr} < NUM_D4) ? r_ram[rd_addr] : 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_tm1637_responder.sv
// Directed bench for tm1637_responder: bus-master tasks, spec-level frame model, write scoreboard.
`timescale 1ns/1ps
module tb_tm1637_responder;

   localparam int Q = 50;
   localparam int H = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       bus_clk;
   logic       m_dio;
   logic       pin_dio;
   logic       dio_oe;
   logic [7:0] key_code;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       display_on;
   logic [2:0] brightness;
   logic       frame_err;
   logic [2:0] dbg_state;

   assign pin_dio = m_dio & ~dio_oe;

   tm1637_responder #(.SYNC_STAGES(2), .NUM_DIGITS(6)) dut (
      .clk(clk), .rst(rst), .tm1637_clk(bus_clk), .tm1637_dio(pin_dio),
      .dio_oe(dio_oe), .key_code(key_code), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .display_on(display_on), .brightness(brightness),
      .frame_err(frame_err), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // spec-level model of the display controller
   logic [10:0] exp_q[$];
   logic [2:0]  m_ptr = 3'd0;
   logic        m_fixed = 1'b0;
   int          m_kind = 0;   // 0 command, 1 data, 2 extra, 3 ignore
   logic        m_disp_on = 1'b0;
   logic [2:0]  m_bright = 3'd0;
   int          m_err = 0;

   task automatic model_reset();
      m_ptr = 3'd0; m_fixed = 1'b0; m_kind = 0; m_disp_on = 1'b0; m_bright = 3'd0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      case (m_kind)
         0: begin
            if (b[7:6] == 2'b01) begin m_fixed = b[2]; m_kind = 2; end
            else if (b[7:6] == 2'b11) begin m_ptr = b[2:0]; m_kind = 1; end
            else if (b[7:6] == 2'b10) begin m_disp_on = b[3]; m_bright = b[2:0]; m_kind = 2; end
            else begin m_err++; m_kind = 3; end
         end
         1: begin
            if (int'(m_ptr) < 6) exp_q.push_back({m_ptr, b});
            else m_err++;
            if (!m_fixed) m_ptr = (int'(m_ptr) == 5) ? 3'd0 : m_ptr + 3'd1;
         end
         2: m_err++;
         default: ;
      endcase
   endtask

   // scoreboard: every write strobe and error pulse the DUT emits
   int          wr_seen = 0;
   int          err_seen = 0;
   logic [10:0] last_wr = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL wr_unexpected: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
            end else begin
               check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
            end
            wr_seen++;
            last_wr = {wr_addr, wr_data};
         end
         if (frame_err) err_seen++;
      end
   end

   // driver tasks
   task automatic bus_start();
      m_dio = 1'b1; #Q; bus_clk = 1'b1; #Q; m_dio = 1'b0; #Q; bus_clk = 1'b0; #Q;
      m_kind = 0;
   endtask

   task automatic bus_stop();
      m_dio = 1'b0; #Q; bus_clk = 1'b1; #Q; m_dio = 1'b1; #(4*Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         m_dio = b[i]; #Q; bus_clk = 1'b1; #Q;
         if (i == 7) check("oe_before_ack", 32'(dio_oe), 32'd0);
         #Q; bus_clk = 1'b0; #Q;
      end
   endtask

   task automatic ack_clock(input bit chk_release);
      m_dio = 1'b1; #Q; bus_clk = 1'b1; #Q;
      check("ack_low", 32'(pin_dio), 32'd0);
      #Q; bus_clk = 1'b0; #Q;
      if (chk_release) check("ack_release", 32'(dio_oe), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit chk_release);
      model_byte(b);
      send_bits(b, 8);
      ack_clock(chk_release);
   endtask

   task automatic frame(input logic [7:0] b0, b1, b2, b3, input int n);
      logic [7:0] bs [4];
      bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
      bus_start();
      for (int i = 0; i < n; i++) send_byte(bs[i], 1'b1);
      bus_stop();
   endtask

   task automatic check_state(input string tag);
      check({tag, "_display_on"}, 32'(display_on), 32'(m_disp_on));
      check({tag, "_brightness"}, 32'(brightness), 32'(m_bright));
      check({tag, "_frame_err_count"}, 32'(err_seen), 32'(m_err));
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   logic [7:0] got;

   initial begin
      rst = 1'b1; bus_clk = 1'b1; m_dio = 1'b1; key_code = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      check("rst_dio_oe", 32'(dio_oe), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_display_on", 32'(display_on), 32'd0);
      check("rst_brightness", 32'(brightness), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_state_idle", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      #100;

      // reset asserted while the responder holds the ACK low
      bus_start();
      model_byte(8'h8F);
      send_bits(8'h8F, 8);
      m_dio = 1'b1; #Q; bus_clk = 1'b1; #Q;
      check("midack_oe_held", 32'(dio_oe), 32'd1);
      check("midack_display_on", 32'(display_on), 32'd1);
      check("midack_brightness", 32'(brightness), 32'd7);
      rst = 1'b1; #1;
      check("midack_oe_async_release", 32'(dio_oe), 32'd0);
      model_reset();
      #20;
      check_state("after_reset");
      rst = 1'b0; #Q;
      bus_clk = 1'b0; #Q;
      bus_stop();

      // auto-increment writes
      frame(8'h40, 8'h00, 8'h00, 8'h00, 1);
      frame(8'hC0, 8'h3F, 8'h06, 8'h5B, 4);
      #100;
      check("auto_inc_write_count", 32'(wr_seen), 32'd3);
      check("auto_inc_last_write", 32'(last_wr), 32'({3'd2, 8'h5B}));
      check_state("auto_inc");

      // fixed address, then auto-increment wrap at the last digit
      frame(8'h44, 8'h00, 8'h00, 8'h00, 1);
      frame(8'hC5, 8'h11, 8'h22, 8'h00, 3);
      frame(8'h40, 8'h00, 8'h00, 8'h00, 1);
      frame(8'hC5, 8'h11, 8'h22, 8'h00, 3);
      #100;
      check("wrap_last_write", 32'(last_wr), 32'({3'd0, 8'h22}));
      check_state("fixed_wrap");

      // display control, then an extra byte after the control byte
      frame(8'h8A, 8'h00, 8'h00, 8'h00, 1);
      #100;
      check("disp_on_literal", 32'(display_on), 32'd1);
      check("disp_bright_literal", 32'(brightness), 32'd2);
      frame(8'h80, 8'h12, 8'h00, 8'h00, 2);
      #100;
      check("disp_off_literal", 32'(display_on), 32'd0);
      check_state("display");

      // key read
      key_code = 8'hA5;
      bus_start();
      send_byte(8'h42, 1'b0);
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
         m_dio = 1'b1; #Q; bus_clk = 1'b1; #Q;
         got[i] = pin_dio;
         #Q; bus_clk = 1'b0; #Q;
      end
      check("read_release_after_8th", 32'(dio_oe), 32'd0);
      bus_stop();
      check("read_key_byte", 32'(got), 32'hA5);
      key_code = 8'h00;

      // out-of-range digit address
      frame(8'hC6, 8'h77, 8'h00, 8'h00, 2);
      #100;
      check_state("bad_addr");

      // START after a partial byte, then a clean address frame
      bus_start();
      send_bits(8'hFF, 4);
      m_err++;
      bus_start();
      send_byte(8'hC1, 1'b1);
      send_byte(8'h5B, 1'b1);
      bus_stop();
      #100;
      check("restart_last_write", 32'(last_wr), 32'({3'd1, 8'h5B}));
      check_state("restart");

      // invalid command: remaining bytes ignored
      frame(8'h00, 8'hC0, 8'h99, 8'h00, 3);
      #100;
      check_state("invalid_cmd");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
